cell_bist_ctrl: RTL
===================

// Module: cell_bist_ctrl
// PURPOSE
//   Built-in self-test controller for the gate/DFF cell library: the driving and observing end of a mapped netlist.
//   Generates pseudo-random stimulus vectors (Galois LFSR) into a DUT built from library cells.
//   Compacts the DUT responses in a MISR and compares the final signature against a golden value.
//   Sits beside the DUT in the test harness; results read by host/testbench via DONE/PASS/SIG.
// PARAMETERS
//   N          8        stimulus width (DUT input count), >=2
//   M          8        response width (DUT output count), >=2
//   PATTERNS   255      vectors issued per run, >=1
//   LAT        1        DUT latency in C cycles (0 = combinational DUT, 1 = one DFF stage), 0..15
//   SEED       1        LFSR start value; SEED==0 is replaced by 1 (no lock-up)
//   LFSR_TAPS  8'hB8    Galois feedback mask, width N
//   MISR_TAPS  8'hB8    MISR feedback mask, width M
//   GOLDEN     0        expected final signature, width M
// PORTS
//   C          in   1  clock, rising edge
//   RN         in   1  synchronous reset, active low
//   START      in   1  start a run; sampled in IDLE or DONE only
//   RESP       in   M  DUT outputs
//   STIM       out  N  DUT inputs (LFSR state)
//   STIM_VALID out  1  STIM carries a counted pattern this cycle
//   BUSY       out  1  run in progress (RUN or FLUSH)
//   DONE       out  1  run complete, results stable
//   PASS       out  1  SIG==GOLDEN; meaningful only while DONE=1
//   SIG        out  M  MISR signature
// BEHAVIOUR
//   Reset (RN=0 at a C edge): state IDLE; STIM=SEED'; SIG=0; STIM_VALID=BUSY=DONE=PASS=0; counters and valid pipe cleared.
//     Reset mid-run aborts immediately; there are no partial results.
//   FSM IDLE -> RUN -> FLUSH -> DONE.
//   IDLE:  START=1 -> RUN next cycle; STIM=SEED', SIG=0, cnt=0.
//   RUN:   STIM_VALID=1, BUSY=1; each cycle LFSR steps, cnt++.
//          After the cycle with cnt==PATTERNS-1 -> FLUSH (LAT>0) or DONE (LAT==0).
//   FLUSH: STIM_VALID=0, STIM holds last+1 LFSR state; waits LAT cycles for in-flight responses.
//   DONE:  DONE=1, BUSY=0, PASS=(SIG==GOLDEN), held indefinitely.
//          START=1 -> RUN with SIG cleared and STIM reloaded (same as from IDLE).
//   START in RUN/FLUSH is ignored (no restart, no queue).
//   LFSR step (Galois, right shift): s' = (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
//   Capture: STIM_VALID delayed by LAT stages (vpipe).
//     MISR updates only when the delayed valid is 1:
//     sig' = {sig[M-2:0],1'b0} ^ (sig[M-1] ? MISR_TAPS : 0) ^ RESP.
//     LAT==0 -> RESP is compacted in the same cycle as STIM_VALID.
//   Exactly PATTERNS responses are compacted per run.
//   Cycle count from START sample to DONE=1 is PATTERNS+LAT+1.
//   All arithmetic is modulo width; cnt width is clog2(PATTERNS+1).
// STRUCTURE
//   Package cell_bist_pkg: state enum (IDLE, RUN, FLUSH, DONE); lfsr_step/misr_step functions.
//   Sub-module cell_bist_misr (M, MISR_TAPS): enable, clear, RESP in, SIG out.
//   FSM, LFSR, counter and valid pipe stay in the top module.
// TESTING
//   N=4, LFSR_TAPS=4'hC, SEED=1, LAT=0: START -> STIM=1,C,6,3,D,A,5 on successive RUN cycles.
//   RESP tied 0, GOLDEN=0, PATTERNS=10 -> DONE at cycle 11 after START; SIG=0; PASS=1.
//   DUT = bank of DFF cells (RESP=STIM delayed 1), LAT=1 -> DONE at PATTERNS+2;
//     SIG equals the model signature. With LAT=0 the model mismatches -> PASS=0.
//   RN driven low mid-RUN (cnt=5) -> next edge: IDLE, all outputs 0, STIM=SEED.
//     A new START then completes normally.
//   START pulsed during RUN and FLUSH -> ignored; DONE timing unchanged.
//     START in DONE -> fresh run gives identical SIG.
//   SEED=0 -> first STIM=1; PATTERNS=1 -> a single vector, DONE after LAT+2 cycles.

Source files
------------

// File: rtl/cell_bist_pkg.sv
// Shared types and step functions for the cell-library BIST controller.
// Functions work on 32-bit containers; callers truncate to their own width.
package cell_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'h0);
  endfunction

  // Bit w of the result is junk shifted out of the register; the caller drops it.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] taps,
                                            input logic [31:0] d, input int w);
    return (s << 1) ^ (s[w-1] ? taps : 32'h0) ^ d;
  endfunction

endpackage

// File: rtl/cell_bist_misr.sv
// Multiple-input signature register compacting DUT responses.
// Clear wins over enable so a restart always begins from a zero signature.
module cell_bist_misr
  import cell_bist_pkg::*;
#(
  parameter int            M         = 8,
  parameter logic [M-1:0]  MISR_TAPS = M'(8'hB8)
) (
  input  logic         C,
  input  logic         RN,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [M-1:0] resp_i,
  output logic [M-1:0] sig_o
);

  logic [M-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i)
      sig_d = '0;
    else if (en_i)
      sig_d = M'(misr_step(32'(sig_q), 32'(MISR_TAPS), 32'(resp_i), M));
  end

  always_ff @(posedge C) begin
    if (!RN) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST controller: LFSR stimulus, pattern counter, latency-matched valid pipe
// and MISR signature check against a golden value.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for START
//   ST_RUN   | issuing one counted pattern per cycle
//   ST_FLUSH | waiting LAT cycles for in-flight responses
//   ST_DONE  | results stable, PASS valid, START re-arms
module cell_bist_ctrl
  import cell_bist_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           M         = 8,
  parameter int           PATTERNS  = 255,
  parameter int           LAT       = 1,
  parameter logic [N-1:0] SEED      = N'(1),
  parameter logic [N-1:0] LFSR_TAPS = N'(8'hB8),
  parameter logic [M-1:0] MISR_TAPS = M'(8'hB8),
  parameter logic [M-1:0] GOLDEN    = '0
) (
  input  logic         C,
  input  logic         RN,
  input  logic         START,
  input  logic [M-1:0] RESP,
  output logic [N-1:0] STIM,
  output logic         STIM_VALID,
  output logic         BUSY,
  output logic         DONE,
  output logic         PASS,
  output logic [M-1:0] SIG
);

  localparam logic [N-1:0] SEED_EFF = (SEED == '0) ? N'(1) : SEED;
  localparam int           CW       = $clog2(PATTERNS + 1);

  bist_state_e    state_q, state_d;
  logic [N-1:0]   lfsr_q, lfsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     fcnt_q, fcnt_d;
  logic           start_ok, last_pat, cap_en;

  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_pat = (state_q == ST_RUN) && (cnt_q == CW'(PATTERNS - 1));

  always_ff @(posedge C) begin
    if (!RN) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (START) state_d = ST_RUN;
      ST_RUN:           if (last_pat) state_d = (LAT > 0) ? ST_FLUSH : ST_DONE;
      ST_FLUSH:         if (fcnt_q == 4'd0) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    STIM_VALID = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    PASS       = 1'b0;
    case (state_q)
      ST_RUN:   begin STIM_VALID = 1'b1; BUSY = 1'b1; end
      ST_FLUSH: BUSY = 1'b1;
      ST_DONE:  begin DONE = 1'b1; PASS = (SIG == GOLDEN); end
      default:  ;
    endcase
  end

  // The last RUN cycle still steps, so STIM shows last+1 from FLUSH onward.
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    if (start_ok) begin
      lfsr_d = SEED_EFF;
      cnt_d  = '0;
    end else if (state_q == ST_RUN) begin
      lfsr_d = N'(lfsr_step(32'(lfsr_q), 32'(LFSR_TAPS)));
      cnt_d  = cnt_q + 1'b1;
      fcnt_d = 4'(LAT - 1);
    end else if (state_q == ST_FLUSH) begin
      fcnt_d = fcnt_q - 4'd1;
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      lfsr_q <= SEED_EFF;
      cnt_q  <= '0;
      fcnt_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign STIM = lfsr_q;

  generate
    if (LAT == 0) begin : g_nopipe
      assign cap_en = STIM_VALID;
    end else begin : g_vpipe
      logic [LAT-1:0] vpipe_q;
      always_ff @(posedge C) begin
        if (!RN) vpipe_q <= '0;
        else     vpipe_q <= LAT'({vpipe_q, STIM_VALID});
      end
      assign cap_en = vpipe_q[LAT-1];
    end
  endgenerate

  cell_bist_misr #(
    .M         (M),
    .MISR_TAPS (MISR_TAPS)
  ) u_misr (
    .C      (C),
    .RN     (RN),
    .en_i   (cap_en),
    .clr_i  (start_ok),
    .resp_i (RESP),
    .sig_o  (SIG)
  );

endmodule
